data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DM_ADDRESS, default 9: byte-address width of the data port.
REQ-002 Parameter DATA_W, default 32: data width.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset: clk is the only clock; reset is sampled on the rising edge of clk and is active-high.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 MemRead  in  1  load request, valid for the current cycle.
REQ-007 MemWrite  in  1  store request, valid for the current cycle.
REQ-008 addr  in  DM_ADDRESS  byte address.
REQ-009 wr_data  in  DATA_W  store data, right-aligned.
REQ-010 func3  in  3  RISC-V load/store width code.
REQ-011 rd_data  out  DATA_W  load result (combinational).
REQ-012 misalign_err  out  1  sticky misaligned/illegal-access flag.

Function
REQ-013 Address map SHALL be: RAM 0x000-0x1EF (124 words, index addr[8:2]); MMIO 0x1F0-0x1FF.
REQ-014 MMIO registers SHALL be: 0x1F0 CYCLE (RO); 0x1F4 LOAD_CNT (RO); 0x1F8 STORE_CNT (RO); 0x1FC STATUS (bit0 = misalign_err, W1C; bits 31:1 read 0).
REQ-015 An access SHALL be legal when func3 and alignment match: loads 000/100 any address; 001/101 need addr[0]=0; 010 needs addr[1:0]=00; stores 000 any address, 001 needs addr[0]=0, 010 needs addr[1:0]=00. Any other func3 or alignment is illegal.
REQ-016 A legal store SHALL update the RAM at the rising edge: SB writes lane addr[1:0] with wr_data[7:0]; SH writes lanes {addr[1],0} and {addr[1],1} with wr_data[15:0]; SW writes the whole word; other lanes are unchanged.
REQ-017 rd_data SHALL be combinational from current contents, with zero wait states.
REQ-018 Load extraction SHALL be: LB (000) sign-extends the selected byte; LBU (100) zero-extends it; LH (001) sign-extends the selected halfword; LHU (101) zero-extends it; LW (010) returns the full word.
REQ-019 rd_data SHALL be 0 when MemRead=0 or the load is illegal.
REQ-020 When MemRead=1 and MemWrite=1 in the same cycle, rd_data SHALL return the pre-write (old) data and the write SHALL commit at the edge.
REQ-021 CYCLE SHALL increment by 1 every clock not in reset and wrap 0xFFFFFFFF -> 0.
REQ-022 LOAD_CNT SHALL increment on each cycle with a legal MemRead=1; STORE_CNT SHALL increment on each cycle with a legal MemWrite=1; both wrap at 2^32; a cycle with both requests increments both.
REQ-023 Loads from MMIO SHALL use the same lane extraction as RAM.
REQ-024 Stores to 0x1F0-0x1FB SHALL be ignored (no state change except STORE_CNT).
REQ-025 A legal store to 0x1FC with wr_data[0]=1 SHALL clear misalign_err; lanes not covering bit 0 have no effect.
REQ-026 Any illegal MemRead or MemWrite cycle SHALL perform no RAM write, no counter increment, and set misalign_err at the next edge.
REQ-027 If a W1C clear and a new illegal access coincide, set SHALL win (misalign_err=1).
REQ-028 MemRead=MemWrite=0 SHALL leave all state unchanged, except that CYCLE still counts.

Reset
REQ-029 While reset=1 at an edge: all 124 RAM words, CYCLE, LOAD_CNT, STORE_CNT and misalign_err SHALL become 0, and requests in that cycle SHALL be ignored.
REQ-030 In the first cycle after reset deasserts, rd_data SHALL be 0 for any RAM load, and CYCLE SHALL read 0 then increment.
REQ-031 Reset asserted mid-sequence SHALL discard the in-flight store; no partial lane update is permitted.

Verification
REQ-032 SW 0x80 data 0xDEADBEEF, then LB/LBU/LH/LHU/LW at 0x80-0x83 -> 0xFFFFFFEF, 0xEF, 0xFFFFBEEF, 0xBEEF, 0xDEADBEEF; LBU at 0x83 -> 0xDE.
REQ-033 SB 0x41 data 0x000000AA over word 0x11223344 at 0x40 -> LW 0x40 = 0x1122AA44; SH 0x42 data 0x5566 -> 0x5566AA44.
REQ-034 SW 0x82, then LH 0x81 -> no RAM change, rd_data=0, misalign_err=1 after edge, LOAD_CNT and STORE_CNT unchanged; SW 0x1FC data 1 -> misalign_err=0.
REQ-035 Same cycle: SW 0x10 data 0x1 over old value 0x7 with LW 0x10 -> rd_data=0x7 that cycle, 0x1 next cycle; LOAD_CNT and STORE_CNT each +1.
REQ-036 Reset 3 cycles, then 10 idle cycles -> LW 0x1F0 = 10 (±0 vs bench count); W1C to 0x1FC coinciding with an illegal LW -> misalign_err stays 1.
REQ-037 Reset asserted during SW 0x20 data 0xFFFFFFFF -> LW 0x20 = 0 after reset.

Source files
------------

// File: rtl/data_mem_responder.sv
// Byte-addressable data memory with RISC-V load/store lane handling and a small
// MMIO block (cycle/load/store counters, sticky misalignment status with W1C clear).
module data_mem_responder #(
   parameter int DM_ADDRESS = 9,
   parameter int DATA_W     = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  MemRead,
   input  logic                  MemWrite,
   input  logic [DM_ADDRESS-1:0] addr,
   input  logic [DATA_W-1:0]     wr_data,
   input  logic [2:0]            func3,
   output logic [DATA_W-1:0]     rd_data,
   output logic                  misalign_err
);

   localparam int RAM_WORDS = 124;

   logic [DATA_W-1:0] r_ram [RAM_WORDS];
   logic [31:0]       r_cycle;
   logic [31:0]       r_loadCnt;
   logic [31:0]       r_storeCnt;
   logic              r_misalignErr;

   logic              w_inRange;
   logic [6:0]        w_wordIdx;
   logic [1:0]        w_lane;
   logic              w_isRam;
   logic              w_isMmio;
   logic              w_loadLegal;
   logic              w_storeLegal;
   logic              w_illegal;
   logic              w_doLoad;
   logic              w_doStore;
   logic              w_w1c;
   logic [DATA_W-1:0] w_word;
   logic [7:0]        w_byte;
   logic [15:0]       w_half;
   logic [3:0]        w_byteEn;
   logic [31:0]       w_wrWord;

   // Anything above the 512-byte window decodes to nothing
   assign w_inRange = (addr & ~DM_ADDRESS'(511)) == '0;
   assign w_wordIdx = addr[8:2];
   assign w_lane    = addr[1:0];
   assign w_isRam   = w_inRange && (w_wordIdx < 7'd124);
   assign w_isMmio  = w_inRange && (w_wordIdx >= 7'd124);

   always_comb begin
      w_loadLegal  = 1'b0;
      w_storeLegal = 1'b0;
      case (func3)
         3'b000: begin
            w_loadLegal  = 1'b1;
            w_storeLegal = 1'b1;
         end
         3'b100: w_loadLegal = 1'b1;
         3'b001: begin
            w_loadLegal  = ~addr[0];
            w_storeLegal = ~addr[0];
         end
         3'b101: w_loadLegal = ~addr[0];
         3'b010: begin
            w_loadLegal  = (addr[1:0] == 2'b00);
            w_storeLegal = (addr[1:0] == 2'b00);
         end
         default: ;
      endcase
   end

   // An illegal half of a combined request blocks every side effect of the cycle
   assign w_illegal = (MemRead & ~w_loadLegal) | (MemWrite & ~w_storeLegal);
   assign w_doLoad  = MemRead & ~w_illegal;
   assign w_doStore = MemWrite & ~w_illegal;

   always_comb begin
      w_word = '0;
      if (w_isRam) begin
         w_word = r_ram[w_wordIdx];
      end else if (w_isMmio) begin
         case (w_wordIdx[1:0])
            2'b00:   w_word = DATA_W'(r_cycle);
            2'b01:   w_word = DATA_W'(r_loadCnt);
            2'b10:   w_word = DATA_W'(r_storeCnt);
            default: w_word = DATA_W'(r_misalignErr);
         endcase
      end
   end

   assign w_byte = w_word[{w_lane, 3'b000} +: 8];
   assign w_half = w_word[{w_lane[1], 4'b0000} +: 16];

   always_comb begin
      rd_data = '0;
      if (MemRead && w_loadLegal) begin
         case (func3)
            3'b000:  rd_data = {{(DATA_W-8){w_byte[7]}}, w_byte};
            3'b100:  rd_data = {{(DATA_W-8){1'b0}}, w_byte};
            3'b001:  rd_data = {{(DATA_W-16){w_half[15]}}, w_half};
            3'b101:  rd_data = {{(DATA_W-16){1'b0}}, w_half};
            3'b010:  rd_data = w_word;
            default: rd_data = '0;
         endcase
      end
   end

   // Store data is replicated across lanes so each enabled lane picks up its byte
   always_comb begin
      w_byteEn = 4'b0000;
      w_wrWord = '0;
      case (func3[1:0])
         2'b00: begin
            w_byteEn = 4'b0001 << w_lane;
            w_wrWord = {4{wr_data[7:0]}};
         end
         2'b01: begin
            w_byteEn = addr[1] ? 4'b1100 : 4'b0011;
            w_wrWord = {2{wr_data[15:0]}};
         end
         2'b10: begin
            w_byteEn = 4'b1111;
            w_wrWord = wr_data[31:0];
         end
         default: ;
      endcase
   end

   assign w_w1c = w_doStore && w_isMmio && (w_wordIdx[1:0] == 2'b11) &&
                  w_byteEn[0] && w_wrWord[0];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < RAM_WORDS; i++) begin
            r_ram[i] <= '0;
         end
      end else if (w_doStore && w_isRam) begin
         for (int l = 0; l < 4; l++) begin
            if (w_byteEn[l]) begin
               r_ram[w_wordIdx][8*l +: 8] <= w_wrWord[8*l +: 8];
            end
         end
      end
   end

   // A new illegal access outranks a simultaneous W1C clear
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cycle       <= '0;
         r_loadCnt     <= '0;
         r_storeCnt    <= '0;
         r_misalignErr <= 1'b0;
      end else begin
         r_cycle <= r_cycle + 32'd1;
         if (w_doLoad) begin
            r_loadCnt <= r_loadCnt + 32'd1;
         end
         if (w_doStore) begin
            r_storeCnt <= r_storeCnt + 32'd1;
         end
         if (w_illegal) begin
            r_misalignErr <= 1'b1;
         end else if (w_w1c) begin
            r_misalignErr <= 1'b0;
         end
      end
   end

   assign misalign_err = r_misalignErr;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: byte-array reference model checked
// every cycle, directed literal scenarios, then randomized traffic.
module tb_data_mem_responder;

   logic        clk = 1'b0;
   logic        reset;
   logic        MemRead;
   logic        MemWrite;
   logic [8:0]  addr;
   logic [31:0] wr_data;
   logic [2:0]  func3;
   logic [31:0] rd_data;
   logic        misalign_err;

   int          checks = 0;
   int          errors = 0;

   // Reference model: plain byte array for RAM plus the four MMIO values
   logic [7:0]  mMem [0:495];
   logic [31:0] mCycle;
   logic [31:0] mLoad;
   logic [31:0] mStore;
   logic        mErr;
   logic [31:0] lastRd;

   always #5 clk = ~clk;

   data_mem_responder #(.DM_ADDRESS(9), .DATA_W(32)) dut (
      .clk          (clk),
      .reset        (reset),
      .MemRead      (MemRead),
      .MemWrite     (MemWrite),
      .addr         (addr),
      .wr_data      (wr_data),
      .func3        (func3),
      .rd_data      (rd_data),
      .misalign_err (misalign_err)
   );

   function automatic int accessSize(input logic [2:0] f3);
      case (f3[1:0])
         2'b00:   return 1;
         2'b01:   return 2;
         2'b10:   return 4;
         default: return 0;
      endcase
   endfunction

   function automatic bit isLegal(input bit isLoad, input logic [8:0] a, input logic [2:0] f3);
      int sz;
      sz = accessSize(f3);
      if (sz == 0) return 0;
      if (f3[2] && (!isLoad || sz == 4)) return 0;
      return (int'(a) % sz) == 0;
   endfunction

   function automatic logic [7:0] byteAt(input int a);
      logic [31:0] regVal;
      if (a < 496) return mMem[a];
      case ((a - 496) / 4)
         0:       regVal = mCycle;
         1:       regVal = mLoad;
         2:       regVal = mStore;
         default: regVal = {31'b0, mErr};
      endcase
      return 8'(regVal >> (8 * (a % 4)));
   endfunction

   function automatic logic [31:0] modelRead(input logic rd, input logic [8:0] a, input logic [2:0] f3);
      logic [31:0] v;
      int n;
      if (!rd || !isLegal(1, a, f3)) return 32'h0;
      n = accessSize(f3);
      v = 32'h0;
      for (int k = 0; k < n; k++) begin
         v = v | (32'(byteAt(int'(a) + k)) << (8 * k));
      end
      if (!f3[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
      return v;
   endfunction

   task automatic modelUpdate(input logic rst, input logic rd, input logic wr,
                              input logic [8:0] a, input logic [31:0] d, input logic [2:0] f3);
      bit bad;
      if (rst) begin
         for (int i = 0; i < 496; i++) mMem[i] = 8'h00;
         mCycle = 0;
         mLoad  = 0;
         mStore = 0;
         mErr   = 1'b0;
         return;
      end
      mCycle = mCycle + 1;
      bad = (rd && !isLegal(1, a, f3)) || (wr && !isLegal(0, a, f3));
      if (bad) begin
         mErr = 1'b1;
      end else begin
         if (rd) mLoad = mLoad + 1;
         if (wr) begin
            mStore = mStore + 1;
            if (int'(a) < 496) begin
               for (int k = 0; k < accessSize(f3); k++) mMem[int'(a) + k] = d[8*k +: 8];
            end else if (a == 9'h1FC && d[0]) begin
               mErr = 1'b0;
            end
         end
      end
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock: drive at the falling edge, compare before the rising edge, advance model after it
   task automatic applyStimulus(input logic rst, input logic rd, input logic wr,
                                input logic [8:0] a, input logic [31:0] d, input logic [2:0] f3);
      reset    = rst;
      MemRead  = rd;
      MemWrite = wr;
      addr     = a;
      wr_data  = d;
      func3    = f3;
      #1;
      checkOutput("model_rd_data", rd_data, modelRead(rd, a, f3));
      checkOutput("model_misalign_err", {31'b0, misalign_err}, {31'b0, mErr});
      lastRd = rd_data;
      @(posedge clk);
      modelUpdate(rst, rd, wr, a, d, f3);
      @(negedge clk);
   endtask

   task automatic doReset(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 1'b0, 9'h0, 32'h0, 3'b000);
   endtask

   task automatic idle();
      applyStimulus(1'b0, 1'b0, 1'b0, 9'h0, 32'h0, 3'b000);
   endtask

   task automatic load(input logic [8:0] a, input logic [2:0] f3);
      applyStimulus(1'b0, 1'b1, 1'b0, a, 32'h0, f3);
   endtask

   task automatic store(input logic [8:0] a, input logic [31:0] d, input logic [2:0] f3);
      applyStimulus(1'b0, 1'b0, 1'b1, a, d, f3);
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      logic        rRst;
      logic        rRd;
      logic        rWr;
      logic [8:0]  rA;
      logic [2:0]  rF;
      logic [31:0] rD;

      reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0;
      addr = '0; wr_data = '0; func3 = '0;
      for (int i = 0; i < 496; i++) mMem[i] = 8'h00;
      mCycle = 0; mLoad = 0; mStore = 0; mErr = 1'b0;
      @(negedge clk);

      // Post-reset values and CYCLE starting from zero
      doReset(3);
      checkOutput("reset_err", {31'b0, misalign_err}, 32'd0);
      load(9'h1F0, 3'b010); checkOutput("cycle_after_reset", lastRd, 32'd0);
      load(9'h000, 3'b010); checkOutput("ram_after_reset", lastRd, 32'd0);
      load(9'h1F0, 3'b010); checkOutput("cycle_counting", lastRd, 32'd2);

      // Load extraction on a known word
      store(9'h080, 32'hDEADBEEF, 3'b010);
      load(9'h080, 3'b000); checkOutput("lb_80", lastRd, 32'hFFFFFFEF);
      load(9'h080, 3'b100); checkOutput("lbu_80", lastRd, 32'h000000EF);
      load(9'h080, 3'b001); checkOutput("lh_80", lastRd, 32'hFFFFBEEF);
      load(9'h080, 3'b101); checkOutput("lhu_80", lastRd, 32'h0000BEEF);
      load(9'h080, 3'b010); checkOutput("lw_80", lastRd, 32'hDEADBEEF);
      load(9'h083, 3'b100); checkOutput("lbu_83", lastRd, 32'h000000DE);
      load(9'h083, 3'b000); checkOutput("lb_83", lastRd, 32'hFFFFFFDE);
      load(9'h082, 3'b001); checkOutput("lh_82", lastRd, 32'hFFFFDEAD);

      // Partial stores leave other lanes intact
      store(9'h040, 32'h11223344, 3'b010);
      store(9'h041, 32'h000000AA, 3'b000);
      load(9'h040, 3'b010); checkOutput("sb_41", lastRd, 32'h1122AA44);
      store(9'h042, 32'h00005566, 3'b001);
      load(9'h040, 3'b010); checkOutput("sh_42", lastRd, 32'h5566AA44);

      // Misaligned accesses: no side effects, sticky flag, W1C clear
      doReset(2);
      store(9'h080, 32'hDEADBEEF, 3'b010);
      store(9'h082, 32'h12345678, 3'b010);
      checkOutput("err_set_sw82", {31'b0, misalign_err}, 32'd1);
      load(9'h081, 3'b001); checkOutput("lh_81_zero", lastRd, 32'd0);
      load(9'h1F4, 3'b010); checkOutput("load_cnt_unchanged", lastRd, 32'd0);
      load(9'h1F8, 3'b010); checkOutput("store_cnt_unchanged", lastRd, 32'd1);
      load(9'h080, 3'b010); checkOutput("ram_unchanged", lastRd, 32'hDEADBEEF);
      load(9'h1FC, 3'b010); checkOutput("status_read", lastRd, 32'd1);
      store(9'h1FC, 32'h00000001, 3'b010);
      checkOutput("err_cleared", {31'b0, misalign_err}, 32'd0);

      // Simultaneous read and write returns old data
      doReset(1);
      store(9'h010, 32'h00000007, 3'b010);
      applyStimulus(1'b0, 1'b1, 1'b1, 9'h010, 32'h00000001, 3'b010);
      checkOutput("rw_old_data", lastRd, 32'h00000007);
      load(9'h010, 3'b010); checkOutput("rw_new_data", lastRd, 32'h00000001);
      load(9'h1F4, 3'b010); checkOutput("rw_load_cnt", lastRd, 32'd2);
      load(9'h1F8, 3'b010); checkOutput("rw_store_cnt", lastRd, 32'd2);

      // CYCLE after idle period, and set-beats-clear on the status flag
      doReset(3);
      for (int i = 0; i < 10; i++) idle();
      load(9'h1F0, 3'b010); checkOutput("cycle_10_idle", lastRd, 32'd10);
      load(9'h081, 3'b001);
      applyStimulus(1'b0, 1'b1, 1'b1, 9'h1FD, 32'h00000001, 3'b010);
      checkOutput("set_wins_misaligned", {31'b0, misalign_err}, 32'd1);
      applyStimulus(1'b0, 1'b0, 1'b1, 9'h1FC, 32'h00000001, 3'b011);
      checkOutput("set_wins_bad_func3", {31'b0, misalign_err}, 32'd1);
      store(9'h1FD, 32'h00000001, 3'b000);
      checkOutput("w1c_wrong_lane", {31'b0, misalign_err}, 32'd1);
      store(9'h1FC, 32'h00000000, 3'b000);
      checkOutput("w1c_zero_data", {31'b0, misalign_err}, 32'd1);
      store(9'h1FC, 32'h00000001, 3'b000);
      checkOutput("w1c_sb_clear", {31'b0, misalign_err}, 32'd0);

      // Store coinciding with reset is discarded
      store(9'h020, 32'h12345678, 3'b010);
      applyStimulus(1'b1, 1'b0, 1'b1, 9'h020, 32'hFFFFFFFF, 3'b010);
      load(9'h020, 3'b010); checkOutput("store_during_reset", lastRd, 32'd0);

      // Randomized traffic against the model
      for (int i = 0; i < 800; i++) begin
         rRst = ($urandom_range(0, 63) == 0);
         rRd  = 1'($urandom_range(0, 1));
         rWr  = ($urandom_range(0, 2) == 0);
         rF   = 3'($urandom_range(0, 7));
         rA   = 9'($urandom_range(0, 511));
         rD   = $urandom;
         if ($urandom_range(0, 3) == 0) rA = 9'h1F0 | 9'($urandom_range(0, 15));
         if ($urandom_range(0, 3) != 0) begin
            case (rF[1:0])
               2'b01:   rA[0] = 1'b0;
               2'b10:   rA[1:0] = 2'b00;
               default: ;
            endcase
         end
         applyStimulus(rRst, rRd, rWr, rA, rD, rF);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
